// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and default coefficients for the 8-tap FIR MAC.
// The defaults form a symmetric low-pass kernel that sums to 20.
package fir_pkg;
  localparam int TAP_W  = 8;
  localparam int NTAPS  = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 19;
  localparam int IDX_W  = $clog2(NTAPS);
  localparam int PROD_W = TAP_W + COEF_W;

  localparam logic [COEF_W-1:0] DEF_COEF0 = 8'd1;
  localparam logic [COEF_W-1:0] DEF_COEF1 = 8'd2;
  localparam logic [COEF_W-1:0] DEF_COEF2 = 8'd3;
  localparam logic [COEF_W-1:0] DEF_COEF3 = 8'd4;
  localparam logic [COEF_W-1:0] DEF_COEF4 = 8'd4;
  localparam logic [COEF_W-1:0] DEF_COEF5 = 8'd3;
  localparam logic [COEF_W-1:0] DEF_COEF6 = 8'd2;
  localparam logic [COEF_W-1:0] DEF_COEF7 = 8'd1;

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;
endpackage

// File: rtl/fir_mac_if.sv
// Request/result bundle between the tap-window stage (master) and the FIR MAC (slave).
interface fir_mac_if;
  import fir_pkg::*;
  logic             start;
  logic [TAP_W-1:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic             busy;
  logic [ACC_W-1:0] y;
  logic             y_valid;

  modport master (output start, A0, A1, A2, A3, A4, A5, A6, A7,
                  input  busy, y, y_valid);
  modport slave  (input  start, A0, A1, A2, A3, A4, A5, A6, A7,
                  output busy, y, y_valid);
endinterface

// File: rtl/fir_mac.sv
// Sequential 8-tap FIR: captures the tap window on start, then walks one shared
// 8x8 multiplier across the taps (tap 0 first) and pulses y_valid with the sum.
module fir_mac
  import fir_pkg::*;
#(
  parameter logic [COEF_W-1:0] COEF0 = DEF_COEF0,
  parameter logic [COEF_W-1:0] COEF1 = DEF_COEF1,
  parameter logic [COEF_W-1:0] COEF2 = DEF_COEF2,
  parameter logic [COEF_W-1:0] COEF3 = DEF_COEF3,
  parameter logic [COEF_W-1:0] COEF4 = DEF_COEF4,
  parameter logic [COEF_W-1:0] COEF5 = DEF_COEF5,
  parameter logic [COEF_W-1:0] COEF6 = DEF_COEF6,
  parameter logic [COEF_W-1:0] COEF7 = DEF_COEF7
) (
  input  logic        clk,
  input  logic        reset,
  fir_mac_if.slave    bus
);
  localparam logic [COEF_W-1:0] COEF [NTAPS] =
    '{COEF0, COEF1, COEF2, COEF3, COEF4, COEF5, COEF6, COEF7};
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);

  state_t              state, state_next;
  logic [TAP_W-1:0]    taps [NTAPS];
  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc, acc_sum, y_q;
  logic [PROD_W-1:0]   prod;
  logic                busy_q, vld_q;
  logic                capture, done;

  // Single time-multiplexed multiplier; max sum 8*255*255 fits in ACC_W, no wrap.
  assign prod    = taps[idx] * COEF[idx];
  assign acc_sum = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)   state_next = MAC;
      MAC:     if (idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture = (state == IDLE) && bus.start;
    done    = (state == MAC) && (idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      acc    <= '0;
      y_q    <= '0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
    end else begin
      busy_q <= (state_next == MAC);
      vld_q  <= done;
      if (capture) begin
        taps[0] <= bus.A0;
        taps[1] <= bus.A1;
        taps[2] <= bus.A2;
        taps[3] <= bus.A3;
        taps[4] <= bus.A4;
        taps[5] <= bus.A5;
        taps[6] <= bus.A6;
        taps[7] <= bus.A7;
        acc     <= '0;
        idx     <= '0;
      end else if (state == MAC) begin
        // idx wraps 7 -> 0 on the same edge that returns to IDLE
        idx <= idx + 1'b1;
        acc <= acc_sum;
        if (done) y_q <= acc_sum;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;
endmodule

// File: tb/tb_fir_mac.sv
// Randomized self-checking bench for fir_mac against a plain dot-product model.
module tb_fir_mac;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_mac_if bus ();
  fir_mac_if bus2 ();

  fir_mac u_dut (.clk(clk), .reset(reset), .bus(bus));
  fir_mac #(.COEF0(8'd255), .COEF1(8'd255), .COEF2(8'd255), .COEF3(8'd255),
            .COEF4(8'd255), .COEF5(8'd255), .COEF6(8'd255), .COEF7(8'd255))
    u_big (.clk(clk), .reset(reset), .bus(bus2));

  int errors = 0;
  int checks = 0;
  int tv     [8];
  int snap   [8];
  int cf     [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  int cf_big [8] = '{255, 255, 255, 255, 255, 255, 255, 255};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(input int t [8], input int c [8]);
    int s = 0;
    for (int k = 0; k < 8; k++) s += t[k] * c[k];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_taps();
    for (int k = 0; k < 8; k++) tv[k] = $urandom_range(0, 255);
  endtask

  task automatic drive_taps();
    bus.A0 = 8'(tv[0]); bus.A1 = 8'(tv[1]); bus.A2 = 8'(tv[2]); bus.A3 = 8'(tv[3]);
    bus.A4 = 8'(tv[4]); bus.A5 = 8'(tv[5]); bus.A6 = 8'(tv[6]); bus.A7 = 8'(tv[7]);
    bus2.A0 = bus.A0; bus2.A1 = bus.A1; bus2.A2 = bus.A2; bus2.A3 = bus.A3;
    bus2.A4 = bus.A4; bus2.A5 = bus.A5; bus2.A6 = bus.A6; bus2.A7 = bus.A7;
  endtask

  // One start pulse on both DUTs, cycle-exact check of busy/y_valid, then result.
  task automatic run_conv(input string tag);
    int exp_y, exp_big;
    exp_y   = ref_y(tv, cf);
    exp_big = ref_y(tv, cf_big);
    drive_taps();
    bus.start = 1'b1; bus2.start = 1'b1;
    tick();
    bus.start = 1'b0; bus2.start = 1'b0;
    chk({tag, "_busy0"}, int'(bus.busy), 1);
    chk({tag, "_vld0"}, int'(bus.y_valid), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("%s_vld%0d", tag, k), int'(bus.y_valid), int'(k == 8));
      chk($sformatf("%s_busy%0d", tag, k), int'(bus.busy), int'(k < 8));
    end
    chk({tag, "_y"}, int'(bus.y), exp_y);
    chk({tag, "_ybig"}, int'(bus2.y), exp_big);
    tick();
    chk({tag, "_vld_drop"}, int'(bus.y_valid), 0);
    chk({tag, "_y_hold"}, int'(bus.y), exp_y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y, n;
    reset = 1'b1;
    bus.start = 1'b0; bus2.start = 1'b0;
    for (int k = 0; k < 8; k++) tv[k] = 0;
    drive_taps();
    tick(); tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_vld", int'(bus.y_valid), 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) tv[k] = 10;
    run_conv("flat10");
    chk("flat10_200", int'(bus.y), 200);

    for (int k = 0; k < 8; k++) tv[k] = 255;
    run_conv("max");
    chk("max_520200", int'(bus2.y), 520200);

    for (int k = 0; k < 8; k++) tv[k] = 0;
    tv[3] = 7;
    run_conv("onehot3");
    chk("onehot3_28", int'(bus.y), 28);
    for (int k = 0; k < 8; k++) tv[k] = 0;
    tv[7] = 1;
    run_conv("onehot7");
    chk("onehot7_1", int'(bus.y), 1);

    for (int r = 0; r < 4; r++) begin
      rand_taps();
      run_conv($sformatf("rnd%0d", r));
    end

    // Taps change after capture and a stray start mid-run: neither may matter.
    rand_taps();
    exp_y = ref_y(tv, cf);
    drive_taps();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) begin rand_taps(); drive_taps(); end
      if (k == 3) bus.start = 1'b1;
      if (k == 4) bus.start = 1'b0;
      tick();
      chk($sformatf("mid_vld%0d", k), int'(bus.y_valid), int'(k == 8));
      chk($sformatf("mid_busy%0d", k), int'(bus.busy), int'(k < 8));
    end
    chk("mid_y", int'(bus.y), exp_y);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("mid_no_second_vld", int'(bus.y_valid), 0);
    end
    chk("mid_idle", int'(bus.busy), 0);

    // start held high: accepted every 9th edge with the taps present at that edge.
    for (int c = 0; c < 30; c++) begin
      rand_taps();
      drive_taps();
      bus.start = 1'b1;
      tick();
      if (c % 9 == 0) snap = tv;
      chk($sformatf("hold_vld%0d", c), int'(bus.y_valid), int'(c % 9 == 8));
      chk($sformatf("hold_busy%0d", c), int'(bus.busy), int'(c % 9 != 8));
      if (c % 9 == 8) chk($sformatf("hold_y%0d", c), int'(bus.y), ref_y(snap, cf));
    end
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk("hold_drain", int'(bus.busy), 0);
    chk("hold_last_y", int'(bus.y), ref_y(snap, cf));

    // Reset mid-convolution aborts without output.
    rand_taps();
    drive_taps();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_y", int'(bus.y), 0);
    chk("abort_vld", int'(bus.y_valid), 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("abort_no_vld", int'(bus.y_valid), 0);
    end
    rand_taps();
    run_conv("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
